serial_alu_ctrl: RTL and testbench



---
 rtl/serial_alu_pkg.sv | 36 +++
 rtl/serial_alu_ctrl_slice.sv | 35 +++
 rtl/serial_alu_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_alu_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared opcodes, FSM states and op helpers for the bit-serial ALU.
// SERIAL_ALU_SLT_EN enables signed set-less-than on op 110.
package serial_alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic op_legal(input logic [2:0] op);
`ifdef SERIAL_ALU_SLT_EN
      return op != OP_RSV;
`else
      return (op != OP_RSV) && (op != OP_SLT);
`endif
   endfunction

endpackage

// File: rtl/serial_alu_ctrl_slice.sv
// Combinational 1-bit ALU slice: logic ops plus a full adder.
// B is inverted here for subtract-style ops so the adder does a-b.
module alu_bit_slice
   import serial_alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [2:0] op,
   output logic       res,
   output logic       cout
);

   logic bx;
   logic sum;

   assign bx   = b ^ is_sub(op);
   assign sum  = a ^ bx ^ cin;
   assign cout = (a & bx) | (a & cin) | (bx & cin);

   always_comb begin
      res = 1'b0;
      unique case (1'b1)
         op == OP_AND: res = a & b;
         op == OP_OR:  res = a | b;
         op == OP_ADD: res = sum;
         op == OP_SUB: res = sum;
         op == OP_XOR: res = a ^ b;
         op == OP_NOR: res = ~(a | b);
         op == OP_SLT: res = sum;
         default:      res = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU engine: one bit per cycle, LSB first, one shared slice.
// SERIAL_ALU_SLT_EN enables signed set-less-than on op 110.
module serial_alu_ctrl
   import serial_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             illegal_op
);

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sr, b_sr, r_sr;
   logic [WIDTH-1:0] r_fin, res_val;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic             cy;
   logic             s_res, s_cout;
   logic             last, ovf;
   logic             legal, arith, slt;

   alu_bit_slice u_slice (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (cy),
      .op   (op_q),
      .res  (s_res),
      .cout (s_cout)
   );

   assign last  = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
   assign r_fin = {s_res, r_sr[WIDTH-1:1]};
   assign ovf   = cy ^ s_cout;
   assign legal = op_legal(op_q);
   assign arith = is_arith(op_q);
   assign slt   = legal && (op_q == OP_SLT);

   // On the MSB cycle, cy is the carry into the MSB and s_res its sign.
   always_comb begin
      res_val = '0;
      if (!legal)
         res_val = '0;
      else if (slt)
         res_val[0] = s_res ^ ovf;
      else
         res_val = r_fin;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = RUN;
         end
         RUN: begin
            if (last)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr       <= '0;
         b_sr       <= '0;
         r_sr       <= '0;
         op_q       <= OP_AND;
         cnt        <= '0;
         cy         <= 1'b0;
         result     <= '0;
         carry_out  <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
         illegal_op <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_sr <= a;
         b_sr <= b;
         r_sr <= '0;
         op_q <= op;
         cnt  <= '0;
         cy   <= is_sub(op);
      end else if (state == RUN) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         r_sr <= r_fin;
         cy   <= s_cout;
         if (!last)
            cnt <= cnt + CNT_W'(1);
         if (last) begin
            result     <= res_val;
            zero       <= (res_val == '0);
            carry_out  <= legal && arith && s_cout;
            overflow   <= legal && (arith || slt) && ovf;
            illegal_op <= !legal;
         end
      end
   end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl at WIDTH=8.
// Expected values are hand-computed; honours SERIAL_ALU_SLT_EN.
module tb_serial_alu_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [7:0] a, b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       carry_out, overflow, zero, illegal_op;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;

   always #5 clk = ~clk;

   serial_alu_ctrl #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .carry_out  (carry_out),
      .overflow   (overflow),
      .zero       (zero),
      .illegal_op (illegal_op)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string t, input logic [7:0] r,
                             input logic c, input logic v,
                             input logic z, input logic il);
      chk({t, ".res"}, 32'(result), 32'(r));
      chk({t, ".cy"},  32'(carry_out), 32'(c));
      chk({t, ".ovf"}, 32'(overflow), 32'(v));
      chk({t, ".zero"}, 32'(zero), 32'(z));
      chk({t, ".ill"}, 32'(illegal_op), 32'(il));
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, output int n);
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(n);
   endtask

   task automatic consume(input string t);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({t, ".ov_clr"}, 32'(out_valid), 32'd0);
      chk({t, ".rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 3'b000; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.rdy", 32'(in_ready), 32'd1);
      chk("rst.ov", 32'(out_valid), 32'd0);
      expect_out("rst", 8'h00, 0, 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;

      run_op(3'b000, 8'hCC, 8'hAA, lat);
      chk("and.lat", 32'(lat), 32'd8);
      expect_out("and", 8'h88, 0, 0, 0, 0);
      consume("and");

      run_op(3'b010, 8'h7F, 8'h01, lat);
      chk("add.lat", 32'(lat), 32'd8);
      expect_out("add", 8'h80, 0, 1, 0, 0);
      consume("add");

      run_op(3'b011, 8'h05, 8'h05, lat);
      expect_out("sub0", 8'h00, 1, 0, 1, 0);
      consume("sub0");

      run_op(3'b011, 8'h00, 8'h01, lat);
      expect_out("subb", 8'hFF, 0, 0, 0, 0);
      consume("subb");

      run_op(3'b101, 8'hF0, 8'h0F, lat);
      expect_out("nor", 8'h00, 0, 0, 1, 0);
      consume("nor");

      run_op(3'b001, 8'hA0, 8'h0A, lat);
      expect_out("or", 8'hAA, 0, 0, 0, 0);
      consume("or");

      // reset while an ADD is mid-flight
      @(negedge clk);
      op = 3'b010; a = 8'h0F; b = 8'h01; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mrst.rdy", 32'(in_ready), 32'd1);
      chk("mrst.ov", 32'(out_valid), 32'd0);
      expect_out("mrst", 8'h00, 0, 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("mrst.drop", 32'(out_valid), 32'd0);

      // backpressure with a competing offer held throughout
      run_op(3'b010, 8'h10, 8'h20, lat);
      expect_out("bp", 8'h30, 0, 0, 0, 0);
      @(negedge clk);
      op = 3'b100; a = 8'h3C; b = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp.ov", 32'(out_valid), 32'd1);
         chk("bp.rdy", 32'(in_ready), 32'd0);
         chk("bp.res", 32'(result), 32'h30);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp.idle_ov", 32'(out_valid), 32'd0);
      chk("bp.idle_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp.acc", 32'(in_ready), 32'd0);
      wait_done(lat);
      chk("bp2.lat", 32'(lat), 32'd8);
      expect_out("bp2", 8'hC3, 0, 0, 0, 0);
      consume("bp2");

      run_op(3'b110, 8'hFE, 8'h01, lat);
      chk("slt.lat", 32'(lat), 32'd8);
`ifdef SERIAL_ALU_SLT_EN
      expect_out("slt", 8'h01, 0, 0, 0, 0);
`else
      expect_out("slt", 8'h00, 0, 0, 1, 1);
`endif
      consume("slt");

      run_op(3'b111, 8'h12, 8'h34, lat);
      chk("rsv.lat", 32'(lat), 32'd8);
      expect_out("rsv", 8'h00, 0, 0, 1, 1);
      consume("rsv");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
